// File: rtl/sync_fifo_if.sv
//------------------------------------------------------------------------------
// sync_fifo_if
//   Bundle of the producer/consumer request and status signals of sync_fifo.
//
//   Request/accept semantics: a write is accepted at a rising edge of clk
//   exactly when we=1 and full=0; a read is accepted exactly when re=1 and
//   empty=0. full and empty act as the "not ready" indications for the two
//   sides. A request made while not ready is ignored without error, so a
//   requester may either gate its own request or simply hold it until it is
//   accepted. clr outranks both requests in the cycle in which it is high.
//
//   master : producer/consumer side (drives clr, din, we, re)
//   slave  : FIFO side (drives dout, full, empty, almost_full, almost_empty, cnt)
//------------------------------------------------------------------------------
interface sync_fifo_if #(
   parameter int DW = 8,
   parameter int AW = 8
);
   logic          clr;
   logic [DW-1:0] din;
   logic          we;
   logic          re;
   logic [DW-1:0] dout;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic [AW:0]   cnt;

   modport master (
      output clr, din, we, re,
      input  dout, full, empty, almost_full, almost_empty, cnt
   );

   modport slave (
      input  clr, din, we, re,
      output dout, full, empty, almost_full, almost_empty, cnt
   );
endinterface

// File: rtl/sync_fifo.sv
//------------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO of 2**AW words of DW bits, with a registered read port,
//   registered full/empty/almost flags and a registered fill count.
//
//   Ports
//     clk  : clock, all state changes on the rising edge
//     rst  : asynchronous reset, active-high
//     bus  : sync_fifo_if.slave
//              clr          synchronous clear, active-high
//              din / we     write data / write request
//              re           read request
//              dout         read data, valid right after the accepting edge
//              full, empty  fill-state flags
//              almost_full  free slots <= AFL
//              almost_empty stored words <= AEL
//              cnt          stored words, 0..2**AW
//------------------------------------------------------------------------------
module sync_fifo #(
   parameter int DW  = 8,
   parameter int AW  = 8,
   parameter int AFL = 4,
   parameter int AEL = 4
) (
   input logic        clk,
   input logic        rst,
   sync_fifo_if.slave bus
);

   localparam logic [AW:0] DEPTH_C  = {1'b1, {AW{1'b0}}};
   // almost_full: DEPTH - cnt <= AFL  <=>  cnt >= DEPTH - AFL
   localparam logic [AW:0] AF_THR_C = DEPTH_C - (AW+1)'(AFL);
   localparam logic [AW:0] AE_THR_C = (AW+1)'(AEL);

   logic [DW-1:0] mem [2**AW];

   // Pointers carry one extra MSB so that wp-rp spans 0..DEPTH.
   logic [AW:0]   wp_q, wp_d;
   logic [AW:0]   rp_q, rp_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          empty_q, empty_d;
   logic          full_q, full_d;
   logic          ae_q, ae_d;
   logic          af_q, af_d;
   logic [DW-1:0] dout_q, dout_d;

   logic          wr_acc;
   logic          rd_acc;

   // Requests are qualified here, so ungated requests are harmless.
   assign wr_acc = bus.we & ~full_q;
   assign rd_acc = bus.re & ~empty_q;

   always_comb begin
      wp_d   = wp_q;
      rp_d   = rp_q;
      dout_d = dout_q;
      if (bus.clr) begin
         wp_d   = '0;
         rp_d   = '0;
         dout_d = '0;
      end else begin
         if (wr_acc) wp_d = wp_q + {{AW{1'b0}}, 1'b1};
         if (rd_acc) begin
            rp_d   = rp_q + {{AW{1'b0}}, 1'b1};
            dout_d = mem[rp_q[AW-1:0]];
         end
      end
      // Flags are computed from the post-edge pointers so they register in
      // step with the pointer update.
      cnt_d   = wp_d - rp_d;
      empty_d = (cnt_d == '0);
      full_d  = (cnt_d == DEPTH_C);
      ae_d    = (cnt_d <= AE_THR_C);
      af_d    = (cnt_d >= AF_THR_C);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q    <= '0;
         rp_q    <= '0;
         cnt_q   <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         ae_q    <= 1'b1;
         af_q    <= 1'b0;
         dout_q  <= '0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         cnt_q   <= cnt_d;
         empty_q <= empty_d;
         full_q  <= full_d;
         ae_q    <= ae_d;
         af_q    <= af_d;
         dout_q  <= dout_d;
      end
   end

   // Storage is deliberately left out of reset; a clear blocks the write.
   always_ff @(posedge clk) begin
      if (wr_acc && !bus.clr) mem[wp_q[AW-1:0]] <= bus.din;
   end

   assign bus.dout         = dout_q;
   assign bus.cnt          = cnt_q;
   assign bus.empty        = empty_q;
   assign bus.full         = full_q;
   assign bus.almost_empty = ae_q;
   assign bus.almost_full  = af_q;

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

   localparam int DW    = 8;
   localparam int AW    = 8;
   localparam int DEPTH = 256;
   localparam int AFL   = 4;
   localparam int AEL   = 4;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   sync_fifo_if #(.DW(DW), .AW(AW)) bus ();

   sync_fifo #(.DW(DW), .AW(AW), .AFL(AFL), .AEL(AEL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- scoreboard ----------------
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] exp_dout;
   int n_pass;
   int n_total;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic check_outputs(input string tag);
      int sz;
      sz = exp_q.size();
      chk({tag, ".dout"},  32'(bus.dout), 32'(exp_dout));
      chk({tag, ".cnt"},   32'(bus.cnt), 32'(sz));
      chk({tag, ".empty"}, 32'(bus.empty), 32'(sz == 0));
      chk({tag, ".full"},  32'(bus.full), 32'(sz == DEPTH));
      chk({tag, ".ae"},    32'(bus.almost_empty), 32'(sz <= AEL));
      chk({tag, ".af"},    32'(bus.almost_full), 32'((DEPTH - sz) <= AFL));
   endtask

   // ---------------- driver tasks ----------------
   // One clock cycle with the reference queue model updated at the edge.
   task automatic cycle(input logic c, input logic w, input logic r,
                        input logic [DW-1:0] d, input string tag);
      logic m_full;
      logic m_empty;
      bus.clr = c;
      bus.we  = w;
      bus.re  = r;
      bus.din = d;
      m_full  = (exp_q.size() == DEPTH);
      m_empty = (exp_q.size() == 0);
      @(posedge clk);
      if (c) begin
         exp_q.delete();
         exp_dout = '0;
      end else begin
         if (r && !m_empty) exp_dout = exp_q.pop_front();
         if (w && !m_full) exp_q.push_back(d);
      end
      #3;
      check_outputs(tag);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0, "idle");
   endtask

   task automatic wr(input logic [DW-1:0] d, input string tag);
      cycle(1'b0, 1'b1, 1'b0, d, tag);
   endtask

   task automatic rd(input string tag);
      cycle(1'b0, 1'b0, 1'b1, '0, tag);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (exp_q.size() > 0 && guard < 2*DEPTH) begin
         rd("drain");
         guard++;
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic          clr;
      logic          we;
      logic          re;
      logic [DW-1:0] din;
      logic [DW-1:0] e_dout;
      logic [AW:0]   e_cnt;
      logic          e_empty;
      logic          e_full;
      logic          e_ae;
      logic          e_af;
   } vec_t;

   vec_t vecs[15];

   task automatic apply_vec(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      bus.clr = v.clr;
      bus.we  = v.we;
      bus.re  = v.re;
      bus.din = v.din;
      @(posedge clk);
      #3;
      chk({tag, ".dout"},  32'(bus.dout), 32'(v.e_dout));
      chk({tag, ".cnt"},   32'(bus.cnt), 32'(v.e_cnt));
      chk({tag, ".empty"}, 32'(bus.empty), 32'(v.e_empty));
      chk({tag, ".full"},  32'(bus.full), 32'(v.e_full));
      chk({tag, ".ae"},    32'(bus.almost_empty), 32'(v.e_ae));
      chk({tag, ".af"},    32'(bus.almost_full), 32'(v.e_af));
   endtask

   // ---------------- test sequence ----------------
   initial begin
      n_pass   = 0;
      n_total  = 0;
      exp_dout = '0;
      bus.clr  = 1'b0;
      bus.we   = 1'b0;
      bus.re   = 1'b0;
      bus.din  = '0;

      //          clr  we   re   din    dout   cnt   emp  full ae   af
      vecs[0]  = '{1'b0,1'b1,1'b0,8'hA5, 8'h00, 9'd1, 1'b0,1'b0,1'b1,1'b0};
      vecs[1]  = '{1'b0,1'b1,1'b0,8'h3C, 8'h00, 9'd2, 1'b0,1'b0,1'b1,1'b0};
      vecs[2]  = '{1'b0,1'b0,1'b1,8'h00, 8'hA5, 9'd1, 1'b0,1'b0,1'b1,1'b0};
      vecs[3]  = '{1'b0,1'b1,1'b1,8'h77, 8'h3C, 9'd1, 1'b0,1'b0,1'b1,1'b0};
      vecs[4]  = '{1'b0,1'b0,1'b1,8'h00, 8'h77, 9'd0, 1'b1,1'b0,1'b1,1'b0};
      vecs[5]  = '{1'b0,1'b0,1'b1,8'h00, 8'h77, 9'd0, 1'b1,1'b0,1'b1,1'b0};
      vecs[6]  = '{1'b0,1'b1,1'b1,8'h11, 8'h77, 9'd1, 1'b0,1'b0,1'b1,1'b0};
      vecs[7]  = '{1'b0,1'b0,1'b1,8'h00, 8'h11, 9'd0, 1'b1,1'b0,1'b1,1'b0};
      vecs[8]  = '{1'b0,1'b1,1'b0,8'h22, 8'h11, 9'd1, 1'b0,1'b0,1'b1,1'b0};
      vecs[9]  = '{1'b0,1'b1,1'b0,8'h33, 8'h11, 9'd2, 1'b0,1'b0,1'b1,1'b0};
      vecs[10] = '{1'b0,1'b1,1'b0,8'h44, 8'h11, 9'd3, 1'b0,1'b0,1'b1,1'b0};
      vecs[11] = '{1'b0,1'b1,1'b0,8'h55, 8'h11, 9'd4, 1'b0,1'b0,1'b1,1'b0};
      vecs[12] = '{1'b0,1'b1,1'b0,8'h66, 8'h11, 9'd5, 1'b0,1'b0,1'b0,1'b0};
      vecs[13] = '{1'b1,1'b1,1'b1,8'h99, 8'h00, 9'd0, 1'b1,1'b0,1'b1,1'b0};
      vecs[14] = '{1'b0,1'b0,1'b1,8'h00, 8'h00, 9'd0, 1'b1,1'b0,1'b1,1'b0};

      // Reset asserted before any clock edge: outputs settle immediately.
      rst = 1'b1;
      #1;
      check_outputs("reset0");
      @(posedge clk);
      @(posedge clk);
      #3;
      rst = 1'b0;

      // Directed vectors.
      for (int i = 0; i < 15; i++) apply_vec(vecs[i], i);
      exp_q.delete();
      exp_dout = '0;

      // Fill with idle gaps, overflow by one, then drain with gaps.
      for (int i = 0; i < DEPTH; i++) begin
         wr(8'($urandom_range(0, 255)), "fill");
         idle(i % 5);
      end
      chk("fill_full", 32'(bus.full), 32'd1);
      chk("fill_cnt", 32'(bus.cnt), 32'd256);
      wr(8'h5A, "overflow");
      chk("overflow_cnt", 32'(bus.cnt), 32'd256);
      for (int i = 0; i < DEPTH; i++) begin
         rd("drainfill");
         idle(i % 5);
      end
      chk("drain_empty", 32'(bus.empty), 32'd1);
      rd("underflow");
      rd("underflow2");

      // Concurrent access at cnt=10.
      for (int i = 0; i < 10; i++) wr(8'($urandom_range(0, 255)), "conc_pre");
      for (int i = 0; i < 20; i++) begin
         cycle(1'b0, 1'b1, 1'b1, 8'($urandom_range(0, 255)), "conc");
         chk("conc_cnt10", 32'(bus.cnt), 32'd10);
      end
      drain();

      // Concurrent access at full: only the read is accepted.
      for (int i = 0; i < DEPTH; i++) wr(8'(i ^ 8'h5C), "fill2");
      cycle(1'b0, 1'b1, 1'b1, 8'hEE, "full_rw");
      chk("full_rw_cnt", 32'(bus.cnt), 32'd255);
      chk("full_rw_full", 32'(bus.full), 32'd0);
      drain();

      // Wrap: interleaved bursts of 1-3 writes and 1-3 reads.
      for (int b = 0; b < 3*DEPTH; b++) begin
         int nw;
         int nr;
         nw = $urandom_range(1, 3);
         nr = $urandom_range(1, 3);
         for (int i = 0; i < nw; i++) wr(8'($urandom_range(0, 255)), "wrap_w");
         for (int i = 0; i < nr; i++) rd("wrap_r");
      end
      drain();

      // Asynchronous reset mid-operation.
      wr(8'hC3, "ar_w");
      for (int i = 0; i < 5; i++) wr(8'(8'h10 + i), "ar_w");
      rd("ar_r");
      chk("ar_pre_dout", 32'(bus.dout), 32'h0C3);
      rst = 1'b1;
      #1;
      exp_q.delete();
      exp_dout = '0;
      check_outputs("async_rst");
      @(posedge clk);
      #3;
      rst = 1'b0;
      idle(1);

      // Synchronous clear at cnt=100.
      for (int i = 0; i < 100; i++) wr(8'($urandom_range(0, 255)), "clr_fill");
      chk("clr_pre_cnt", 32'(bus.cnt), 32'd100);
      cycle(1'b1, 1'b0, 1'b0, '0, "clr");
      chk("clr_cnt", 32'(bus.cnt), 32'd0);
      chk("clr_empty", 32'(bus.empty), 32'd1);
      wr(8'hAB, "clr_w");
      rd("clr_r");
      chk("clr_dout", 32'(bus.dout), 32'h0AB);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
